// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and pipe_hazard_ctrl.
// The master side is the datapath (drives hazard sources); the slave side is the controller.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_redirect;
  logic       ex_memread;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic       mem_regwrite;
  logic [4:0] mem_rd;
  logic       wb_regwrite;
  logic [4:0] wb_rd;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       memwb_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       mem_err;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_redirect, ex_memread, ex_rs, ex_rt,
           mem_regwrite, mem_rd, wb_regwrite, wb_rd, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
           memwb_bubble, fwd_a, fwd_b, mem_err
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_redirect, ex_memread, ex_rs, ex_rt,
           mem_regwrite, mem_rd, wb_regwrite, wb_rd, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble,
           memwb_bubble, fwd_a, fwd_b, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, redirect flush, memory-wait freeze with watchdog, and EX forwarding selects.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned WAIT_W   = 8,
  parameter int unsigned MAX_WAIT = 200
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz_if
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]        stall_cnt_o,
  output logic [15:0]        flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic lu;
  logic mem_stall;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && m_rd != 5'd0 && m_rd == src)      sel = 2'b10;
    else if (w_we && w_rd != 5'd0 && w_rd == src) sel = 2'b01;
    return sel;
  endfunction

  assign lu = hz_if.ex_memread && hz_if.ex_rt != 5'd0 &&
              (hz_if.ex_rt == hz_if.id_rs ||
               (hz_if.id_uses_rt && hz_if.ex_rt == hz_if.id_rt));
  assign mem_stall = hz_if.dmem_req && !hz_if.dmem_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_d            = state_q;
    wait_cnt_d         = wait_cnt_q;
    hz_if.pc_en        = 1'b1;
    hz_if.ifid_en      = 1'b1;
    hz_if.idex_en      = 1'b1;
    hz_if.exmem_en     = 1'b1;
    hz_if.ifid_flush   = 1'b0;
    hz_if.idex_bubble  = 1'b0;
    hz_if.memwb_bubble = 1'b0;
    hz_if.mem_err      = 1'b0;
    hz_if.fwd_a        = fwd_sel(hz_if.ex_rs, hz_if.mem_regwrite, hz_if.mem_rd,
                                 hz_if.wb_regwrite, hz_if.wb_rd);
    hz_if.fwd_b        = fwd_sel(hz_if.ex_rt, hz_if.mem_regwrite, hz_if.mem_rd,
                                 hz_if.wb_regwrite, hz_if.wb_rd);

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q == MAX_WAIT_C) state_d = ST_ERROR;
          else                          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          // Either the access completed or the request was withdrawn.
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_ERROR: ;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (state_q == ST_ERROR || mem_stall) begin
      hz_if.pc_en        = 1'b0;
      hz_if.ifid_en      = 1'b0;
      hz_if.idex_en      = 1'b0;
      hz_if.exmem_en     = 1'b0;
      hz_if.memwb_bubble = 1'b1;
      hz_if.mem_err      = (state_q == ST_ERROR);
    end else if (lu) begin
      // A redirect in the same cycle is dropped; the branch re-resolves after the bubble.
      hz_if.pc_en       = 1'b0;
      hz_if.ifid_en     = 1'b0;
      hz_if.idex_bubble = 1'b1;
    end else if (hz_if.id_redirect) begin
      hz_if.ifid_flush = 1'b1;
    end

    if (rst) begin
      hz_if.pc_en        = 1'b0;
      hz_if.ifid_en      = 1'b0;
      hz_if.idex_en      = 1'b0;
      hz_if.exmem_en     = 1'b0;
      hz_if.ifid_flush   = 1'b0;
      hz_if.idex_bubble  = 1'b0;
      hz_if.memwb_bubble = 1'b0;
      hz_if.mem_err      = 1'b0;
      hz_if.fwd_a        = 2'b00;
      hz_if.fwd_b        = 2'b00;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!hz_if.pc_en && state_q != ST_ERROR && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (hz_if.ifid_flush && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a cycle-level model of the control rules.
module tb_pipe_hazard_ctrl;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: length of the current uninterrupted memory stall, and sticky error.
  int   waited = 0;
  bit   err = 1'b0;
  int   stall_m = 0;
  int   flush_m = 0;

  pipe_hazard_ctrl_if hz_if ();

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  pipe_hazard_ctrl #(.WAIT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .hz_if       (hz_if.slave)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (hz_if.mem_regwrite && hz_if.mem_rd == src) return 2'b10;
    if (hz_if.wb_regwrite && hz_if.wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble, mem_err, fwd_a, fwd_b}
  function automatic logic [11:0] exp_bundle();
    bit stall, lu;
    logic [3:0] en;
    logic fl, bb, mb, me;
    if (rst) return 12'd0;
    stall = hz_if.dmem_req && !hz_if.dmem_ready;
    lu = hz_if.ex_memread && (hz_if.ex_rt != 0) &&
         ((hz_if.ex_rt == hz_if.id_rs) || (hz_if.id_uses_rt && hz_if.ex_rt == hz_if.id_rt));
    en = 4'b1111; fl = 0; bb = 0; mb = 0; me = 0;
    if (err)                    begin en = 4'b0000; mb = 1; me = 1; end
    else if (stall)             begin en = 4'b0000; mb = 1; end
    else if (lu)                begin en = 4'b0011; bb = 1; end
    else if (hz_if.id_redirect) fl = 1;
    return {en, fl, bb, mb, me, ref_fwd(hz_if.ex_rs), ref_fwd(hz_if.ex_rt)};
  endfunction

  function automatic logic [11:0] obs_bundle();
    return {hz_if.pc_en, hz_if.ifid_en, hz_if.idex_en, hz_if.exmem_en,
            hz_if.ifid_flush, hz_if.idex_bubble, hz_if.memwb_bubble, hz_if.mem_err,
            hz_if.fwd_a, hz_if.fwd_b};
  endfunction

  // Called just after a negedge with the inputs for this cycle applied; returns at the next negedge.
  task automatic cycle(input string tag);
    logic [11:0] e;
    #1;
    e = exp_bundle();
    check(tag, {20'd0, obs_bundle()}, {20'd0, e});
    @(posedge clk);
    if (rst) begin
      waited = 0; err = 0; stall_m = 0; flush_m = 0;
    end else begin
      if (!e[11] && !err && stall_m < 65535) stall_m++;
      if (e[7] && flush_m < 65535) flush_m++;
      if (!err) begin
        if (hz_if.dmem_req && !hz_if.dmem_ready) begin
          waited++;
          if (waited > MAX_WAIT) err = 1;
        end else begin
          waited = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hz_if.id_rs = 0; hz_if.id_rt = 0; hz_if.id_uses_rt = 0; hz_if.id_redirect = 0;
    hz_if.ex_memread = 0; hz_if.ex_rs = 0; hz_if.ex_rt = 0;
    hz_if.mem_regwrite = 0; hz_if.mem_rd = 0; hz_if.wb_regwrite = 0; hz_if.wb_rd = 0;
    hz_if.dmem_req = 0; hz_if.dmem_ready = 0;
  endtask

  initial begin
    clear_inputs();
    hz_if.ex_rs = 3; hz_if.mem_regwrite = 1; hz_if.mem_rd = 3;
    @(negedge clk);

    // Reset: everything low, forwarding forced to 00 even with a matching source.
    #1 check("rst_fwd_a", {30'd0, hz_if.fwd_a}, 32'd0);
    cycle("rst_0");
    cycle("rst_1");
    rst = 0;
    clear_inputs();
    #1 check("post_rst_pc_en", {31'd0, hz_if.pc_en}, 32'd1);
    cycle("run_idle");

    // Load-use: one bubble, then the dependency is gone.
    hz_if.ex_memread = 1; hz_if.ex_rt = 5; hz_if.id_rs = 5;
    #1 check("lu_bubble", {31'd0, hz_if.idex_bubble}, 32'd1);
    cycle("lu");
    hz_if.ex_memread = 0;
    cycle("lu_release");
    hz_if.ex_memread = 1; hz_if.ex_rt = 0; hz_if.id_rs = 0;
    #1 check("lu_r0_pc_en", {31'd0, hz_if.pc_en}, 32'd1);
    cycle("lu_r0");
    hz_if.ex_rt = 6; hz_if.id_rt = 6; hz_if.id_rs = 1; hz_if.id_uses_rt = 0;
    cycle("lu_rt_unused");
    hz_if.id_uses_rt = 1;
    cycle("lu_rt_used");
    clear_inputs();

    // Forwarding priority and register 0.
    hz_if.mem_regwrite = 1; hz_if.wb_regwrite = 1; hz_if.mem_rd = 7; hz_if.wb_rd = 7;
    hz_if.ex_rs = 7;
    #1 check("fwd_a_exmem", {30'd0, hz_if.fwd_a}, 32'd2);
    cycle("fwd_a_exmem_cyc");
    hz_if.mem_regwrite = 0;
    #1 check("fwd_a_memwb", {30'd0, hz_if.fwd_a}, 32'd1);
    cycle("fwd_a_memwb_cyc");
    hz_if.ex_rs = 0; hz_if.ex_rt = 7;
    cycle("fwd_b_memwb");
    hz_if.mem_regwrite = 1;
    #1 check("fwd_b_exmem", {30'd0, hz_if.fwd_b}, 32'd2);
    cycle("fwd_b_exmem_cyc");
    hz_if.mem_rd = 0; hz_if.wb_rd = 0; hz_if.ex_rt = 0;
    cycle("fwd_r0");
    clear_inputs();

    // Redirect suppressed by load-use, then taken.
    hz_if.ex_memread = 1; hz_if.ex_rt = 3; hz_if.id_rs = 3; hz_if.id_redirect = 1;
    #1 check("redir_lu_flush", {31'd0, hz_if.ifid_flush}, 32'd0);
    cycle("redir_lu");
    hz_if.ex_memread = 0;
    #1 check("redir_flush", {31'd0, hz_if.ifid_flush}, 32'd1);
    cycle("redir");
    clear_inputs();

    // Three-cycle memory wait with a load-use hidden under the freeze.
    hz_if.dmem_req = 1; hz_if.dmem_ready = 0;
    hz_if.ex_memread = 1; hz_if.ex_rt = 4; hz_if.id_rs = 4;
    for (int i = 0; i < 3; i++) cycle("mwait");
    hz_if.dmem_ready = 1; hz_if.ex_memread = 0;
    #1 check("mwait_release_pc_en", {31'd0, hz_if.pc_en}, 32'd1);
    cycle("mwait_release");
    hz_if.dmem_req = 0; hz_if.dmem_ready = 0;
    cycle("mwait_after");

    // Withdrawn request returns to RUN and restarts the watchdog count.
    hz_if.dmem_req = 1;
    cycle("wd_a0"); cycle("wd_a1");
    hz_if.dmem_req = 0;
    cycle("wd_drop");
    hz_if.dmem_req = 1;
    for (int i = 0; i < MAX_WAIT; i++) cycle("wd_max_ok");
    hz_if.dmem_ready = 1;
    #1 check("wd_max_no_err", {31'd0, hz_if.mem_err}, 32'd0);
    cycle("wd_max_release");
    hz_if.dmem_ready = 0;

    // Watchdog expiry: ERROR after MAX_WAIT+1 stalled cycles, sticky until reset.
    for (int i = 0; i < MAX_WAIT + 1; i++) cycle("wd_stall");
    #1 check("wd_err", {31'd0, hz_if.mem_err}, 32'd1);
    cycle("wd_err_cyc");
    hz_if.dmem_ready = 1;
    #1 check("wd_err_sticky", {31'd0, hz_if.mem_err}, 32'd1);
    cycle("wd_err_sticky_cyc");
    rst = 1;
    #1 check("wd_rst_err", {31'd0, hz_if.mem_err}, 32'd0);
    cycle("wd_rst");
    rst = 0; hz_if.dmem_req = 0;
    cycle("wd_after_rst");

`ifdef HAZARD_PERF_EN
    // Counters restart after the reset above: 3-cycle wait + 1 load-use + 2 redirects.
    hz_if.dmem_req = 1; hz_if.dmem_ready = 0;
    for (int i = 0; i < 3; i++) cycle("perf_wait");
    hz_if.dmem_ready = 1; cycle("perf_release");
    clear_inputs();
    hz_if.ex_memread = 1; hz_if.ex_rt = 9; hz_if.id_rs = 9; cycle("perf_lu");
    clear_inputs();
    hz_if.id_redirect = 1; cycle("perf_redir0"); cycle("perf_redir1");
    clear_inputs();
    #1;
    check("perf_stall_cnt", {16'd0, stall_cnt}, 32'd4);
    check("perf_flush_cnt", {16'd0, flush_cnt}, 32'd2);
`endif

    // Randomized traffic on a small register range so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      hz_if.id_rs        = 5'($urandom_range(0, 3));
      hz_if.id_rt        = 5'($urandom_range(0, 3));
      hz_if.id_uses_rt   = 1'($urandom);
      hz_if.id_redirect  = ($urandom_range(0, 3) == 0);
      hz_if.ex_memread   = 1'($urandom);
      hz_if.ex_rs        = 5'($urandom_range(0, 3));
      hz_if.ex_rt        = 5'($urandom_range(0, 3));
      hz_if.mem_regwrite = 1'($urandom);
      hz_if.mem_rd       = 5'($urandom_range(0, 3));
      hz_if.wb_regwrite  = 1'($urandom);
      hz_if.wb_rd        = 5'($urandom_range(0, 3));
      hz_if.dmem_req     = ($urandom_range(0, 2) == 0);
      hz_if.dmem_ready   = ($urandom_range(0, 4) < 2);
      cycle("rand");
    end

`ifdef HAZARD_PERF_EN
    #1;
    check("rand_stall_cnt", {16'd0, stall_cnt}, 32'(stall_m));
    check("rand_flush_cnt", {16'd0, flush_cnt}, 32'(flush_m));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
